// File: rtl/i2c_cfg_arbiter.sv
// Round-robin arbiter sharing one I2C byte-write controller
// among NREQ config masters, with NACK retry and END timeout.
module i2c_cfg_arbiter #(
  parameter int NREQ      = 2,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [24*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 fail,
  output logic [23:0]          i2c_data,
  output logic                 i2c_go,
  input  logic                 i2c_end,
  input  logic                 i2c_ack,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [3:0]  RMAX     = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CLEAR,
    S_FINISH
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [PW-1:0] pick;
  logic [PW-1:0] cand;
  logic [PW-1:0] nxt;
  logic          found;
  logic [23:0]   sel;
  logic [3:0]    retry;
  logic [15:0]   timer;
  logic          nack;
  logic          tmo;

  // First requester at or after ptr, wrapping past NREQ-1
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (int'(ptr) + k >= NREQ)
        cand = PW'(int'(ptr) + k - NREQ);
      else
        cand = PW'(int'(ptr) + k);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Frame of the picked requester
  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == PW'(i))
        sel = req_data[24*i +: 24];
    end
  end

  // Pointer moves just past the requester that was served
  always_comb begin
    if (int'(idx) == NREQ - 1)
      nxt = '0;
    else
      nxt = idx + 1'b1;
  end

  assign busy = (state != S_IDLE);

  // Arbitration / transfer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      grant    <= '0;
      done     <= '0;
      fail     <= 1'b0;
      i2c_go   <= 1'b0;
      i2c_data <= '0;
      ptr      <= '0;
      idx      <= '0;
      retry    <= '0;
      timer    <= '0;
      nack     <= 1'b0;
      tmo      <= 1'b0;
    end else begin
      done <= '0;
      fail <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (found) begin
            grant    <= NREQ'(1) << pick;
            idx      <= pick;
            i2c_data <= sel;
            retry    <= '0;
            nack     <= 1'b0;
            tmo      <= 1'b0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          i2c_go <= 1'b1;
          timer  <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + 16'd1;
          if (i2c_end) begin
            i2c_go <= 1'b0;
            nack   <= i2c_ack;
            state  <= S_CLEAR;
          end else if (timer == TMO_LAST) begin
            i2c_go <= 1'b0;
            tmo    <= 1'b1;
            state  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (!i2c_end) begin
            if (tmo) begin
              done  <= grant;
              fail  <= 1'b1;
              state <= S_FINISH;
            end else if (nack && retry < RMAX) begin
              retry <= retry + 4'd1;
              state <= S_ISSUE;
            end else begin
              done  <= grant;
              fail  <= nack;
              state <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          grant <= '0;
          ptr   <= nxt;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cfg_arbiter.sv
// Bench for i2c_cfg_arbiter: random requesters and controller
// against a frame-level round-robin / retry model.
module tb_i2c_cfg_arbiter;

  localparam int NREQ = 2;
  localparam int MAXR = 3;
  localparam int TMO  = 100;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [24*NREQ-1:0]  req_data;
  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     done;
  logic                fail;
  logic [23:0]         i2c_data;
  logic                i2c_go;
  logic                i2c_end;
  logic                i2c_ack;
  logic                busy;

  int n_checks = 0;
  int n_err    = 0;

  logic [23:0]     data_m [NREQ];
  logic [NREQ-1:0] pending;
  int              ptr_m;
  int              last;
  logic [NREQ-1:0] g;

  i2c_cfg_arbiter #(
    .NREQ      (NREQ),
    .MAX_RETRY (MAXR),
    .TIMEOUT   (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .done     (done),
    .fail     (fail),
    .i2c_data (i2c_data),
    .i2c_go   (i2c_go),
    .i2c_end  (i2c_end),
    .i2c_ack  (i2c_ack),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int pick_m();
    for (int k = 0; k < NREQ; k++) begin
      if (pending[(ptr_m + k) % NREQ])
        return (ptr_m + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic raise(input int i, input logic [23:0] d);
    data_m[i]            = d;
    req_data[24*i +: 24] = d;
    req[i]               = 1'b1;
    pending[i]           = 1'b1;
  endtask

  task automatic clear_reqs();
    req     = '0;
    pending = '0;
  endtask

  task automatic ensure();
    if (pending == '0)
      raise((last + 1) % NREQ, 24'($urandom));
  endtask

  // One whole frame, starting at an idle cycle with pending set.
  task automatic run_frame(input int nacks, input bit tmo_f,
                           input int dly, input bit drop,
                           input bit rearm,
                           output logic [NREQ-1:0] gv);
    int w, np, n, prev;
    bit ef, extra;
    prev = last;
    w    = pick_m();
    tick();
    gv = grant;
    chk("grant", grant, oh(w));
    chk("busy", busy, 1);
    if (rearm && prev >= 0 && prev != w && !pending[prev])
      raise(prev, 24'($urandom));
    if (drop)
      req[w] = 1'b0;
    tick();
    chk("go_rise", i2c_go, 1);
    ef = tmo_f || (nacks > MAXR);
    if (tmo_f)
      np = 1;
    else if (nacks > MAXR)
      np = MAXR + 1;
    else
      np = nacks + 1;
    for (int p = 0; p < np; p++) begin
      if (p > 0) begin
        n = 0;
        while (!i2c_go && n < 8) begin
          tick();
          n++;
        end
        chk("retry_go", i2c_go, 1);
      end
      chk("data", i2c_data, data_m[w]);
      if (tmo_f) begin
        n = 0;
        while (i2c_go && n < TMO + 20) begin
          tick();
          n++;
        end
        chk("tmo_len", n, TMO);
      end else begin
        repeat (dly) tick();
        chk("go_hold", i2c_go, 1);
        i2c_end = 1'b1;
        i2c_ack = (p < nacks);
        tick();
        chk("go_fall", i2c_go, 0);
        repeat ($urandom_range(2, 0)) tick();
        i2c_end = 1'b0;
        i2c_ack = 1'b0;
      end
    end
    extra = 1'b0;
    n     = 0;
    while (done == '0 && n < 8) begin
      tick();
      n++;
      if (i2c_go)
        extra = 1'b1;
    end
    chk("done", done, oh(w));
    chk("fail", fail, ef);
    chk("extra_go", extra, 0);
    tick();
    chk("done_pulse", done, 0);
    chk("fail_pulse", fail, 0);
    chk("idle", busy, 0);
    req[w]     = 1'b0;
    pending[w] = 1'b0;
    ptr_m      = (w + 1) % NREQ;
    last       = w;
  endtask

  logic [NREQ-1:0] alt_tbl [4];

  initial begin
    int nk;
    alt_tbl = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    i2c_end  = 1'b0;
    i2c_ack  = 1'b0;
    pending  = '0;
    ptr_m    = 0;
    last     = -1;
    repeat (3) tick();
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_go", i2c_go, 0);
    chk("rst_data", i2c_data, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);

    // both requesters continuously asking: strict alternation
    raise(0, 24'($urandom));
    raise(1, 24'($urandom));
    for (int i = 0; i < 4; i++) begin
      run_frame(0, 0, $urandom_range(6, 1), 0, 1, g);
      chk("rr_seq", g, alt_tbl[i]);
    end

    // single plain frame
    clear_reqs();
    raise(0, 24'h729803);
    run_frame(0, 0, 10, 0, 0, g);

    // NACK twice then ACK; NACK forever
    ensure();
    run_frame(2, 0, 5, 0, 0, g);
    ensure();
    run_frame(7, 0, 3, 0, 0, g);

    // END never comes, both waiting
    raise((last + 1) % NREQ, 24'($urandom));
    if (!pending[last]) raise(last, 24'($urandom));
    run_frame(0, 1, 0, 0, 0, g);
    run_frame(0, 0, 4, 0, 0, g);

    // END on the same cycle the timer expires
    ensure();
    run_frame(0, 0, TMO - 1, 0, 0, g);
    ensure();
    run_frame(1, 0, TMO - 1, 0, 0, g);
    ensure();
    run_frame(5, 0, TMO - 2, 0, 0, g);

    // random traffic
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pending[i] && i != last && $urandom_range(1, 0) == 1)
          raise(i, 24'($urandom));
      end
      ensure();
      nk = $urandom_range(9, 0);
      if (nk < 5)
        nk = 0;
      else if (nk < 8)
        nk = $urandom_range(3, 1);
      else
        nk = $urandom_range(6, 4);
      run_frame(nk, ($urandom_range(11, 0) == 0),
                $urandom_range(12, 1),
                ($urandom_range(3, 0) == 0),
                ($urandom_range(1, 0) == 1), g);
    end

    // reset in the middle of a frame owned by requester 1
    clear_reqs();
    raise(0, 24'($urandom));
    run_frame(0, 0, 2, 0, 0, g);
    raise(1, 24'($urandom));
    tick();
    chk("pre_rst_grant", grant, 2'b10);
    tick();
    chk("pre_rst_go", i2c_go, 1);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_go", i2c_go, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", i2c_data, 0);
    rst   = 1'b0;
    ptr_m = 0;
    last  = -1;
    raise(0, 24'($urandom));
    run_frame(0, 0, 3, 0, 0, g);
    chk("rst_restart", g, 2'b01);
    run_frame(1, 0, 3, 0, 0, g);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
